loop_scheduler: RTL and testbench

- Sequences the accelerator's nested compute loops (layer > patch > frame > block) from the static configuration words produced by the CONFIG block.
- Issues one start pulse per block to the PE datapath and waits for its done.
- Optionally issues one pooling pass per frame and signals completion of the whole run.
- Snapshots the configuration at run start, so configuration changes during a run have no effect.

---
 rtl/loop_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_loop_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_scheduler.sv
// loop_scheduler: walks the nested layer > patch > frame > block loops described by the
// configuration words, launching one PE block per innermost iteration and an optional
// pooling pass after the last block of every frame.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request (only honoured while idle)
//   abort                 synchronous abort back to idle
//   CFG_NumBlk/Frm/Pat/Lay  loop counts minus one (snapshotted when a run starts)
//   CFG_POOL              {pool channel groups[4:0], pool enable, pool kernel}
//   blk_start/blk_done    block launch pulse / block complete pulse
//   pool_start/pool_done  pooling launch pulse / pooling complete pulse
//   cur_blk/frm/pat/lay   registered loop indices of the block being processed
//   pool_kernel           snapshotted pooling kernel field
//   busy                  run in progress (LOAD through DONE)
//   done                  one-cycle run-complete pulse
module loop_scheduler #(
  parameter int unsigned BLK_WIDTH         = 5,
  parameter int unsigned FRAME_WIDTH       = 4,
  parameter int unsigned PATCH_WIDTH       = 4,
  parameter int unsigned LAYER_WIDTH       = 4,
  parameter int unsigned POOL_KERNEL_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [BLK_WIDTH-1:0]           CFG_NumBlk,
  input  logic [FRAME_WIDTH-1:0]         CFG_NumFrm,
  input  logic [PATCH_WIDTH-1:0]         CFG_NumPat,
  input  logic [LAYER_WIDTH-1:0]         CFG_NumLay,
  input  logic [6+POOL_KERNEL_WIDTH-1:0] CFG_POOL,
  output logic                           blk_start,
  input  logic                           blk_done,
  output logic [BLK_WIDTH-1:0]           cur_blk,
  output logic [FRAME_WIDTH-1:0]         cur_frm,
  output logic [PATCH_WIDTH-1:0]         cur_pat,
  output logic [LAYER_WIDTH-1:0]         cur_lay,
  output logic                           pool_start,
  output logic [POOL_KERNEL_WIDTH-1:0]   pool_kernel,
  input  logic                           pool_done,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBlkIssue,
    StBlkWait,
    StPoolIssue,
    StPoolWait,
    StAdvance,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Configuration snapshot, taken on the IDLE->LOAD transition.
  logic [BLK_WIDTH-1:0]           num_blk_q;
  logic [FRAME_WIDTH-1:0]         num_frm_q;
  logic [PATCH_WIDTH-1:0]         num_pat_q;
  logic [LAYER_WIDTH-1:0]         num_lay_q;
  logic [6+POOL_KERNEL_WIDTH-1:0] pool_cfg_q;

  logic [BLK_WIDTH-1:0]   blk_q, blk_d;
  logic [FRAME_WIDTH-1:0] frm_q, frm_d;
  logic [PATCH_WIDTH-1:0] pat_q, pat_d;
  logic [LAYER_WIDTH-1:0] lay_q, lay_d;

  logic load_snap;
  logic pool_en;
  logic last_blk, last_frm, last_pat, last_lay;

  // Channel-group field is carried in the snapshot for downstream use but not decoded here.
  logic unused_pool_groups;
  assign unused_pool_groups = ^pool_cfg_q[6+POOL_KERNEL_WIDTH-1:POOL_KERNEL_WIDTH+1];

  assign load_snap   = (state_q == StIdle) && start;
  assign pool_en     = pool_cfg_q[POOL_KERNEL_WIDTH];
  assign pool_kernel = pool_cfg_q[POOL_KERNEL_WIDTH-1:0];

  assign last_blk = (blk_q == num_blk_q);
  assign last_frm = (frm_q == num_frm_q);
  assign last_pat = (pat_q == num_pat_q);
  assign last_lay = (lay_q == num_lay_q);

  assign cur_blk = blk_q;
  assign cur_frm = frm_q;
  assign cur_pat = pat_q;
  assign cur_lay = lay_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      frm_q      <= '0;
      pat_q      <= '0;
      lay_q      <= '0;
      num_blk_q  <= '0;
      num_frm_q  <= '0;
      num_pat_q  <= '0;
      num_lay_q  <= '0;
      pool_cfg_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      frm_q   <= frm_d;
      pat_q   <= pat_d;
      lay_q   <= lay_d;
      if (load_snap) begin
        num_blk_q  <= CFG_NumBlk;
        num_frm_q  <= CFG_NumFrm;
        num_pat_q  <= CFG_NumPat;
        num_lay_q  <= CFG_NumLay;
        pool_cfg_q <= CFG_POOL;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    frm_d      = frm_q;
    pat_d      = pat_q;
    lay_d      = lay_q;
    blk_start  = 1'b0;
    pool_start = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          blk_d   = '0;
          frm_d   = '0;
          pat_d   = '0;
          lay_d   = '0;
        end
      end
      StLoad: state_d = StBlkIssue;
      StBlkIssue: begin
        blk_start = 1'b1;
        state_d   = StBlkWait;
      end
      StBlkWait: begin
        if (blk_done) begin
          if (!last_blk) begin
            blk_d   = blk_q + 1'b1;
            state_d = StBlkIssue;
          end else if (pool_en) begin
            state_d = StPoolIssue;
          end else begin
            state_d = StAdvance;
          end
        end
      end
      StPoolIssue: begin
        pool_start = 1'b1;
        state_d    = StPoolWait;
      end
      StPoolWait: begin
        if (pool_done) state_d = StAdvance;
      end
      StAdvance: begin
        // Final iteration leaves every index at its last value for the DONE cycle and after.
        if (last_frm && last_pat && last_lay) begin
          state_d = StDone;
        end else begin
          state_d = StBlkIssue;
          blk_d   = '0;
          if (!last_frm) begin
            frm_d = frm_q + 1'b1;
          end else begin
            frm_d = '0;
            if (!last_pat) begin
              pat_d = pat_q + 1'b1;
            end else begin
              pat_d = '0;
              lay_d = lay_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides every transition; indices keep their current values.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      blk_d   = blk_q;
      frm_d   = frm_q;
      pat_d   = pat_q;
      lay_d   = lay_q;
    end
  end

endmodule

// File: tb/tb_loop_scheduler.sv
// Testbench for loop_scheduler: table of configurations with hand-derived expected counts and
// final indices, a nested-loop reference model for the per-block index sequence, randomized
// configurations and handshake latencies, plus hand-written timing, abort and reset sequences.
module tb_loop_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [4:0] CFG_NumBlk;
  logic [3:0] CFG_NumFrm;
  logic [3:0] CFG_NumPat;
  logic [3:0] CFG_NumLay;
  logic [8:0] CFG_POOL;
  logic       blk_start;
  logic       blk_done;
  logic [4:0] cur_blk;
  logic [3:0] cur_frm;
  logic [3:0] cur_pat;
  logic [3:0] cur_lay;
  logic       pool_start;
  logic [2:0] pool_kernel;
  logic       pool_done;
  logic       busy;
  logic       done;

  // Driven by the main sequence.
  logic start_main, blk_done_main;
  bit   resp_en, spur_en;
  int   resp_lat;
  // Driven by the responder.
  logic start_spur, blk_done_resp, blk_done_spur, pool_done_resp, pool_done_spur;

  assign start     = start_main | start_spur;
  assign blk_done  = blk_done_main | blk_done_resp | blk_done_spur;
  assign pool_done = pool_done_resp | pool_done_spur;

  loop_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .CFG_NumBlk (CFG_NumBlk),
    .CFG_NumFrm (CFG_NumFrm),
    .CFG_NumPat (CFG_NumPat),
    .CFG_NumLay (CFG_NumLay),
    .CFG_POOL   (CFG_POOL),
    .blk_start  (blk_start),
    .blk_done   (blk_done),
    .cur_blk    (cur_blk),
    .cur_frm    (cur_frm),
    .cur_pat    (cur_pat),
    .cur_lay    (cur_lay),
    .pool_start (pool_start),
    .pool_kernel(pool_kernel),
    .pool_done  (pool_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Observation log and datapath/pool responder, all evaluated on the falling edge.
  logic [16:0] blk_log[$];
  int pool_cnt = 0;
  int done_cnt = 0;
  int tb_cyc = 0;
  int blk_cd = 0;
  int pool_cd = 0;

  initial begin
    start_spur = 1'b0;
    blk_done_resp = 1'b0;
    blk_done_spur = 1'b0;
    pool_done_resp = 1'b0;
    pool_done_spur = 1'b0;
  end

  always @(negedge clk) begin
    tb_cyc++;
    if (blk_start) blk_log.push_back({cur_lay, cur_pat, cur_frm, cur_blk});
    if (pool_start) pool_cnt++;
    if (done) done_cnt++;

    blk_done_resp  = 1'b0;
    pool_done_resp = 1'b0;
    blk_done_spur  = 1'b0;
    pool_done_spur = 1'b0;
    if (!rst_n) begin
      blk_cd  = 0;
      pool_cd = 0;
    end
    if (blk_cd > 0) begin
      blk_cd--;
      if (blk_cd == 0) blk_done_resp = 1'b1;
      // Stray pool_done while the scheduler waits on a block.
      if (spur_en && blk_cd > 0 && blk_cd == resp_lat - 1) pool_done_spur = 1'b1;
    end
    if (pool_cd > 0) begin
      pool_cd--;
      if (pool_cd == 0) pool_done_resp = 1'b1;
      if (spur_en && pool_cd > 0 && pool_cd == resp_lat - 1) blk_done_spur = 1'b1;
    end
    if (blk_start && resp_en && rst_n) blk_cd = resp_lat;
    if (pool_start && resp_en && rst_n) pool_cd = resp_lat;
    start_spur = spur_en && busy && (tb_cyc % 5 == 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int blk, frm, pat, lay, grp, en, kern;
    int exp_blk, exp_pool;
    int fin_lay, fin_pat, fin_frm, fin_blk;
  } vec_t;

  function automatic logic [16:0] pack(input int l, input int p, input int f, input int b);
    return {l[3:0], p[3:0], f[3:0], b[4:0]};
  endfunction

  task automatic apply_cfg(input vec_t v);
    CFG_NumBlk = v.blk[4:0];
    CFG_NumFrm = v.frm[3:0];
    CFG_NumPat = v.pat[3:0];
    CFG_NumLay = v.lay[3:0];
    CFG_POOL   = {v.grp[4:0], v.en[0], v.kern[2:0]};
  endtask

  task automatic run_vec(input vec_t v, input int lat, input bit spur, input bit mid_change,
                         input string tag);
    logic [16:0] exp_q[$];
    int b0, p0, d0, cyc, n, nerr;
    for (int l = 0; l <= v.lay; l++)
      for (int p = 0; p <= v.pat; p++)
        for (int f = 0; f <= v.frm; f++)
          for (int b = 0; b <= v.blk; b++) exp_q.push_back(pack(l, p, f, b));
    apply_cfg(v);
    resp_lat = lat;
    spur_en  = spur;
    b0 = blk_log.size();
    p0 = pool_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    @(negedge clk);
    if (mid_change) CFG_NumFrm = 4'd0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 30000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    spur_en = 1'b0;
    chk({tag, "/done_count"}, done_cnt - d0, 1);
    n = blk_log.size() - b0;
    chk({tag, "/blk_starts"}, n, v.exp_blk);
    chk({tag, "/pool_starts"}, pool_cnt - p0, v.exp_pool);
    chk({tag, "/model_len"}, n, exp_q.size());
    nerr = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (blk_log[b0 + i] !== exp_q[i]) nerr++;
    chk({tag, "/idx_seq_errs"}, nerr, 0);
    chk({tag, "/final_idx"}, {cur_lay, cur_pat, cur_frm, cur_blk},
        pack(v.fin_lay, v.fin_pat, v.fin_frm, v.fin_blk));
    chk({tag, "/pool_kernel"}, pool_kernel, v.kern);
    chk({tag, "/busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "/busy_after"}, busy, 0);
    chk({tag, "/done_after"}, done, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    vec_t zero_v;
    int b0, d0, cyc;

    // blk frm pat lay grp en kern | blks pools | final lay pat frm blk
    vecs[0] = '{1, 3, 0, 7, 8, 1, 2, 64, 32, 7, 0, 3, 1};
    vecs[1] = '{0, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 2, 1, 3, 0, 7, 6, 0, 1, 2, 0, 0};
    vecs[3] = '{0, 15, 0, 0, 0, 1, 1, 16, 16, 0, 0, 15, 0};
    vecs[4] = '{31, 0, 0, 0, 31, 1, 3, 32, 1, 0, 0, 0, 31};
    vecs[5] = '{0, 0, 15, 15, 0, 0, 0, 256, 0, 15, 15, 0, 0};
    vecs[6] = '{2, 1, 1, 1, 0, 1, 6, 24, 8, 1, 1, 1, 2};
    zero_v  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    start_main = 1'b0;
    blk_done_main = 1'b0;
    abort = 1'b0;
    resp_en = 1'b0;
    spur_en = 1'b0;
    resp_lat = 3;
    apply_cfg(vecs[0]);
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {busy, blk_start, pool_start, done, pool_kernel, cur_lay, cur_pat, cur_frm, cur_blk}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimal run, datapath driven by hand: start, LOAD, ISSUE, WAIT, ADVANCE, DONE, IDLE.
    apply_cfg(zero_v);
    @(negedge clk);
    start_main = 1'b1;
    chk("t0_busy", busy, 0);
    @(negedge clk);
    start_main = 1'b0;
    chk("t1_load_busy", busy, 1);
    chk("t1_load_blk_start", blk_start, 0);
    @(negedge clk);
    chk("t2_blk_start", blk_start, 1);
    @(negedge clk);
    chk("t3_wait_blk_start", blk_start, 0);
    blk_done_main = 1'b1;
    @(negedge clk);
    blk_done_main = 1'b0;
    chk("t4_advance_done", done, 0);
    chk("t4_advance_busy", busy, 1);
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_done_busy", busy, 1);
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_done", done, 0);
    resp_en = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1 + (i % 4), 1'b0, 1'b0, $sformatf("vec%0d", i));

    run_vec(vecs[0], 2, 1'b0, 1'b1, "snapshot");
    run_vec(vecs[0], 3, 1'b1, 1'b0, "spurious");

    // Abort during the 10th block wait.
    apply_cfg(vecs[0]);
    resp_lat = 3;
    b0 = blk_log.size();
    d0 = done_cnt;
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    cyc = 0;
    while (blk_log.size() - b0 < 10 && cyc < 2000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("abort_reach_10th", blk_log.size() - b0, 10);
    @(negedge clk);
    abort = 1'b1;
    chk("abort_in_wait_busy", busy, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_blk_start", blk_start, 0);
    chk("abort_idle_pool_start", pool_start, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_more_blk", blk_log.size() - b0, 10);
    chk("abort_stays_idle", busy, 0);
    run_vec(vecs[0], 3, 1'b0, 1'b0, "after_abort");

    for (int r = 0; r < 6; r++) begin
      v.blk  = $urandom_range(0, 3);
      v.frm  = $urandom_range(0, 2);
      v.pat  = $urandom_range(0, 2);
      v.lay  = $urandom_range(0, 2);
      v.grp  = $urandom_range(0, 31);
      v.en   = $urandom_range(0, 1);
      v.kern = $urandom_range(0, 7);
      v.exp_blk  = (v.blk + 1) * (v.frm + 1) * (v.pat + 1) * (v.lay + 1);
      v.exp_pool = v.en ? (v.frm + 1) * (v.pat + 1) * (v.lay + 1) : 0;
      v.fin_lay = v.lay;
      v.fin_pat = v.pat;
      v.fin_frm = v.frm;
      v.fin_blk = v.blk;
      run_vec(v, $urandom_range(1, 4), r[0], 1'b0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a run.
    apply_cfg(vecs[0]);
    resp_lat = 2;
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    repeat (40) @(negedge clk);
    chk("areset_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_outputs",
        {busy, blk_start, pool_start, done, pool_kernel, cur_lay, cur_pat, cur_frm, cur_blk}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = blk_log.size();
    repeat (10) @(negedge clk);
    #1;
    chk("areset_idle_busy", busy, 0);
    chk("areset_no_blk", blk_log.size() - b0, 0);
    run_vec(vecs[6], 2, 1'b0, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
